// File: rtl/alu_window_ctrl_if.sv
// Decode-side bus of alu_window_ctrl: function code request and registered
// ALU-op / window-pointer results. Master drives func, slave is the controller.
interface alu_window_ctrl_if #(
  parameter int WND_W = 2
);
  logic             func_vld;
  logic [7:0]       func;
  logic [2:0]       alu_op;
  logic             alu_vld;
  logic [WND_W-1:0] wnd;
  logic             ld_wnd;
  logic             illegal;
  logic             stk_ovf;
  logic             stk_unf;

  modport master (
    output func_vld, func,
    input  alu_op, alu_vld, wnd, ld_wnd, illegal, stk_ovf, stk_unf
  );

  modport slave (
    input  func_vld, func,
    output alu_op, alu_vld, wnd, ld_wnd, illegal, stk_ovf, stk_unf
  );
endinterface

// File: rtl/alu_window_ctrl.sv
// Registered one-hot func decoder and register-window pointer owner.
// Define WND_STACK_EN to add the window save/restore stack (WPUSH/WPOP).
module alu_window_ctrl #(
  parameter int NWND    = 4,
  parameter int WND_W   = 2,
  parameter int STACK_D = 4
) (
  input logic              clk,
  input logic              rst,
  alu_window_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    K_IDLE, K_ALU, K_NOP, K_WSET, K_WPUSH, K_WPOP, K_ILL
  } kind_e;

  kind_e            w_kind;
  logic [2:0]       w_op;
  logic [WND_W-1:0] w_n;
  logic             w_n_ok;
  logic [WND_W-1:0] w_wnd_nxt;
  logic             w_ld_nxt;
  logic             w_ill_nxt;

  logic [2:0]       r_alu_op;
  logic             r_alu_vld;
  logic [WND_W-1:0] r_wnd;
  logic             r_ld_wnd;
  logic             r_illegal;

  always_comb begin
    w_kind = K_IDLE;
    w_op   = 3'd6;
    w_n    = WND_W'(bus.func[5:0]);
    w_n_ok = ({1'b0, bus.func[5:0]} < 7'(NWND));
    if (bus.func_vld) begin
      case (bus.func)
        8'h01: begin w_kind = K_ALU; w_op = 3'd0; end
        8'h02: begin w_kind = K_ALU; w_op = 3'd1; end
        8'h04: begin w_kind = K_ALU; w_op = 3'd2; end
        8'h08: begin w_kind = K_ALU; w_op = 3'd3; end
        8'h10: begin w_kind = K_ALU; w_op = 3'd4; end
        8'h20: begin w_kind = K_ALU; w_op = 3'd5; end
        8'h40: w_kind = K_NOP;
`ifdef WND_STACK_EN
        8'hC0: w_kind = K_WPUSH;
        8'hC1: w_kind = K_WPOP;
`endif
        default: w_kind = (bus.func[7:6] == 2'b10) ? K_WSET : K_ILL;
      endcase
    end
  end

`ifdef WND_STACK_EN
  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [SP_W-1:0]  r_sp;
  logic [WND_W-1:0] r_mem [2**IDX_W];
  logic             r_stk_ovf;
  logic             r_stk_unf;
  logic             w_full;
  logic             w_empty;
  logic [SP_W-1:0]  w_sp_dec;

  assign w_full   = (r_sp == SP_W'(STACK_D));
  assign w_empty  = (r_sp == '0);
  assign w_sp_dec = r_sp - SP_W'(1);

  // Push writes on the edge; a following pop reads the stored entry, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (w_kind == K_WPUSH && !w_full)
      r_mem[r_sp[IDX_W-1:0]] <= r_wnd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp      <= '0;
      r_stk_ovf <= 1'b0;
      r_stk_unf <= 1'b0;
    end else begin
      r_stk_ovf <= (w_kind == K_WPUSH) && w_full;
      r_stk_unf <= (w_kind == K_WPOP) && w_empty;
      if (w_kind == K_WPUSH && !w_full)
        r_sp <= r_sp + SP_W'(1);
      else if (w_kind == K_WPOP && !w_empty)
        r_sp <= w_sp_dec;
    end
  end

  assign bus.stk_ovf = r_stk_ovf;
  assign bus.stk_unf = r_stk_unf;
`else
  assign bus.stk_ovf = 1'b0;
  assign bus.stk_unf = 1'b0;
`endif

  always_comb begin
    w_wnd_nxt = r_wnd;
    w_ld_nxt  = 1'b0;
    w_ill_nxt = 1'b0;
    case (w_kind)
      K_WSET: begin
        if (w_n_ok) begin
          w_wnd_nxt = w_n;
          w_ld_nxt  = 1'b1;
        end else begin
          w_ill_nxt = 1'b1;
        end
      end
      K_ILL: w_ill_nxt = 1'b1;
`ifdef WND_STACK_EN
      K_WPOP: begin
        if (!w_empty) begin
          w_wnd_nxt = r_mem[w_sp_dec[IDX_W-1:0]];
          w_ld_nxt  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_op  <= 3'd6;
      r_alu_vld <= 1'b0;
      r_wnd     <= '0;
      r_ld_wnd  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_alu_op  <= w_op;
      r_alu_vld <= (w_kind == K_ALU);
      r_wnd     <= w_wnd_nxt;
      r_ld_wnd  <= w_ld_nxt;
      r_illegal <= w_ill_nxt;
    end
  end

  assign bus.alu_op  = r_alu_op;
  assign bus.alu_vld = r_alu_vld;
  assign bus.wnd     = r_wnd;
  assign bus.ld_wnd  = r_ld_wnd;
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_alu_window_ctrl.sv
// Directed bench for alu_window_ctrl: behavioural model compared every cycle
// plus hand-computed literal expectations; stack tests when WND_STACK_EN is defined.
module tb_alu_window_ctrl;
  localparam int NWND    = 4;
  localparam int WND_W   = 2;
  localparam int STACK_D = 4;
`ifdef WND_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_window_ctrl_if #(.WND_W(WND_W)) bus ();

  alu_window_ctrl #(.NWND(NWND), .WND_W(WND_W), .STACK_D(STACK_D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int op;
    bit av;
    int wnd;
    bit ld;
    bit il;
    bit ov;
    bit un;
  } pred_t;

  localparam pred_t RST_EXP = '{op: 6, av: 0, wnd: 0, ld: 0, il: 0, ov: 0, un: 0};

  pred_t e = RST_EXP;
  int    m_stk[$];

  // Outputs implied by one sampled request, given current window and stack contents.
  function automatic pred_t predict(input bit v, input logic [7:0] f, input int w,
                                    input int depth, input int top);
    pred_t p;
    p = '{op: 6, av: 0, wnd: w, ld: 0, il: 0, ov: 0, un: 0};
    if (!v) return p;
    if ($countones(f) == 1 && f < 8'h40) begin
      p.op = $clog2(f);
      p.av = 1'b1;
    end else if (f == 8'h40) begin
      p.op = 6;
    end else if (f[7:6] == 2'b10) begin
      if (int'(f[5:0]) < NWND) begin p.wnd = int'(f[5:0]); p.ld = 1'b1; end
      else p.il = 1'b1;
    end else if (STK_EN && f == 8'hC0) begin
      if (depth == STACK_D) p.ov = 1'b1;
    end else if (STK_EN && f == 8'hC1) begin
      if (depth == 0) p.un = 1'b1;
      else begin p.wnd = top; p.ld = 1'b1; end
    end else begin
      p.il = 1'b1;
    end
    return p;
  endfunction

  function automatic int stk_top();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e <= RST_EXP;
      m_stk.delete();
    end else begin
      e <= predict(bus.func_vld, bus.func, e.wnd, m_stk.size(), stk_top());
      if (STK_EN && bus.func_vld && bus.func == 8'hC0 && m_stk.size() < STACK_D)
        m_stk.push_back(e.wnd);
      else if (STK_EN && bus.func_vld && bus.func == 8'hC1 && m_stk.size() > 0)
        void'(m_stk.pop_back());
    end
  end

  task automatic check(input string name, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("m.alu_op",  32'(bus.alu_op),  e.op);
      check("m.alu_vld", 32'(bus.alu_vld), int'(e.av));
      check("m.wnd",     32'(bus.wnd),     e.wnd);
      check("m.ld_wnd",  32'(bus.ld_wnd),  int'(e.ld));
      check("m.illegal", 32'(bus.illegal), int'(e.il));
      check("m.stk_ovf", 32'(bus.stk_ovf), int'(e.ov));
      check("m.stk_unf", 32'(bus.stk_unf), int'(e.un));
    end
  end

  task automatic step(input bit v, input logic [7:0] f);
    bus.func_vld = v;
    bus.func     = f;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".alu_op"},  32'(bus.alu_op),  6);
    check({tag, ".alu_vld"}, 32'(bus.alu_vld), 0);
    check({tag, ".wnd"},     32'(bus.wnd),     0);
    check({tag, ".ld_wnd"},  32'(bus.ld_wnd),  0);
    check({tag, ".illegal"}, 32'(bus.illegal), 0);
    check({tag, ".stk_ovf"}, 32'(bus.stk_ovf), 0);
    check({tag, ".stk_unf"}, 32'(bus.stk_unf), 0);
  endtask

  initial begin
    logic [7:0] code;
    bus.func_vld = 1'b0;
    bus.func     = 8'h00;
    #1 rst = 1'b1;
    #12;
    check_reset_vals("rst0");
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // T2: ALU sweep
    for (int i = 0; i < 7; i++) begin
      code = 8'h01 << i;
      step(1'b1, code);
      check("t2.alu_op",  32'(bus.alu_op),  i);
      check("t2.alu_vld", 32'(bus.alu_vld), (i != 6) ? 1 : 0);
    end

    // T3: window set, out-of-range set, repeated set
    step(1'b1, 8'h82);
    check("t3.wnd", 32'(bus.wnd), 2);
    check("t3.ld",  32'(bus.ld_wnd), 1);
    step(1'b1, 8'h84);
    check("t3.ill",    32'(bus.illegal), 1);
    check("t3.wnd_h",  32'(bus.wnd), 2);
    check("t3.ld_off", 32'(bus.ld_wnd), 0);
    step(1'b0, 8'h00);
    check("t3.ill_off", 32'(bus.illegal), 0);
    step(1'b1, 8'h82);
    check("t3.ld_same", 32'(bus.ld_wnd), 1);
    step(1'b1, 8'hBF);
    check("t3.ill_max", 32'(bus.illegal), 1);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h03);
    check("t3.ill_b2b", 32'(bus.illegal), 1);
    check("t3.alu_ill", 32'(bus.alu_vld), 0);

    // T6: func_vld low ignores func; stack codes without the stack
    step(1'b0, 8'h02);
    check("t6.alu_vld", 32'(bus.alu_vld), 0);
    check("t6.alu_op",  32'(bus.alu_op),  6);
`ifndef WND_STACK_EN
    step(1'b1, 8'hC0);
    check("t6.c0_ill", 32'(bus.illegal), 1);
    check("t6.c0_wnd", 32'(bus.wnd), 2);
    check("t6.c0_ovf", 32'(bus.stk_ovf), 0);
    step(1'b1, 8'hC1);
    check("t6.c1_ill", 32'(bus.illegal), 1);
    check("t6.c1_wnd", 32'(bus.wnd), 2);
    check("t6.c1_unf", 32'(bus.stk_unf), 0);
`else
    // T4: WSET1, PUSH, WSET2, PUSH, WSET3, POP, POP
    begin
      logic [7:0] seq [7];
      int         wexp [7];
      seq  = '{8'h81, 8'hC0, 8'h82, 8'hC0, 8'h83, 8'hC1, 8'hC1};
      wexp = '{1, 1, 2, 2, 3, 2, 1};
      for (int i = 0; i < 7; i++) begin
        step(1'b1, seq[i]);
        check("t4.wnd", 32'(bus.wnd), wexp[i]);
      end
      step(1'b1, 8'hC1);
      check("t4.empty", 32'(bus.stk_unf), 1);
    end
    // T5: overflow / underflow bounds
    step(1'b1, 8'h81);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hC0);
      check("t5.ovf", 32'(bus.stk_ovf), (i == 4) ? 1 : 0);
    end
    step(1'b1, 8'h80);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hC1);
      check("t5.unf", 32'(bus.stk_unf), (i == 4) ? 1 : 0);
      check("t5.wnd", 32'(bus.wnd), 1);
    end
`endif

    // T1: asynchronous reset mid-run
    step(1'b1, 8'h83);
    check("t1.wnd3", 32'(bus.wnd), 3);
    bus.func_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_vals("t1");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hC1);
    check("t1.pop_after", 32'(STK_EN ? bus.stk_unf : bus.illegal), 1);
    check("t1.wnd_after", 32'(bus.wnd), 0);
    step(1'b0, 8'h00);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
